// File: rtl/link_pkg.sv
// Shared state encoding and CRC-8 helper for the inter-board frame transmitter.
package link_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ASSERT,
        S_WAIT_HI,
        S_DEASSERT,
        S_WAIT_LO,
        S_CRC_SETUP,
        S_DONE
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam int CRC_MAXW = 64;

    // Folds the low nbits of word into crc, MSB first.
    function automatic logic [7:0] crc8_word(
        input logic [7:0]          crc,
        input logic [CRC_MAXW-1:0] word,
        input int                  nbits
    );
        logic [7:0] c;
        logic       fb;
        c  = crc;
        fb = 1'b0;
        for (int i = CRC_MAXW - 1; i >= 0; i--) begin
            if (i < nbits) begin
                fb = c[7] ^ word[i];
                c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with extra-bit pointers; read data is shown
// combinationally and a full FIFO accepts a write when it is read that cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_wr;
    logic             do_rd;

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = count_o == (AW + 1)'(DEPTH);
    assign empty_o   = count_o == '0;
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/link_frame_tx.sv
// Frame transmitter: buffers words and sends them over the four-phase
// t_data/tsent/trecieve link, optionally closed by a CRC-8 trailer word.
module link_frame_tx #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter bit CRC_EN  = 1'b1,
    parameter int TIMEOUT = 4095
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_we,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] in_count,
    output logic                   in_full,
    output logic [WIDTH-1:0]       t_data,
    output logic                   tsent,
    input  logic                   trecieve,
    output logic                   busy,
    output logic                   frame_done,
    output logic [7:0]             crc,
    output logic                   overflow,
    output logic                   timeout_err
);
    import link_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e           state_q;
    logic [AW:0]      rem_q;
    logic [TW-1:0]    cnt_q;
    logic [7:0]       crc_run_q;
    logic [7:0]       crc_q;
    logic [WIDTH-1:0] t_data_q;
    logic             tsent_q;
    logic             done_q;
    logic             ovf_q;
    logic             tmo_err_q;
    logic             trailer_q;
    logic [WIDTH-1:0] rd_data;
    logic             rd_en;
    logic             empty;
    logic             tmo_hit;

    assign rd_en   = (state_q == S_SETUP) && !empty;
    assign tmo_hit = cnt_q == TW'(TIMEOUT - 1);

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (in_we),
        .wr_data_i (in_data),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data),
        .count_o   (in_count),
        .full_o    (in_full),
        .empty_o   (empty)
    );

    // A write to a full FIFO is only lost if no word leaves that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (in_we && in_full && !rd_en) begin
            ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            cnt_q     <= '0;
            crc_run_q <= 8'h00;
            crc_q     <= 8'h00;
            t_data_q  <= '0;
            tsent_q   <= 1'b0;
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            trailer_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (flush && in_count != '0) begin
                        tmo_err_q <= 1'b0;
                        crc_run_q <= 8'h00;
                        rem_q     <= in_count;
                        trailer_q <= 1'b0;
                        state_q   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    t_data_q  <= rd_data;
                    crc_run_q <= crc8_word(crc_run_q, CRC_MAXW'(rd_data), WIDTH);
                    rem_q     <= rem_q - (AW + 1)'(1);
                    state_q   <= S_ASSERT;
                end
                S_ASSERT: begin
                    tsent_q <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (trecieve) begin
                        state_q <= S_DEASSERT;
                    end else if (tmo_hit) begin
                        tmo_err_q <= 1'b1;
                        tsent_q   <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                S_DEASSERT: begin
                    tsent_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!trecieve) begin
                        if (rem_q != '0) begin
                            state_q <= S_SETUP;
                        end else if (CRC_EN && !trailer_q) begin
                            state_q <= S_CRC_SETUP;
                        end else begin
                            crc_q   <= crc_run_q;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else if (tmo_hit) begin
                        tmo_err_q <= 1'b1;
                        tsent_q   <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                S_CRC_SETUP: begin
                    t_data_q  <= WIDTH'(crc_run_q);
                    trailer_q <= 1'b1;
                    state_q   <= S_ASSERT;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign t_data      = t_data_q;
    assign tsent       = tsent_q;
    assign busy        = state_q != S_IDLE;
    assign frame_done  = done_q;
    assign crc         = crc_q;
    assign overflow    = ovf_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_link_frame_tx.sv
// Scoreboard bench for link_frame_tx: a CRC instance (depth 16) and a
// no-CRC instance (depth 4), both with a short handshake timeout.
module tb_link_frame_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0][7:0] in_data;
    logic [1:0]      in_we;
    logic [1:0]      flush;
    logic [1:0]      trecieve;
    logic [1:0][7:0] t_data;
    logic [1:0][7:0] crc;
    logic [1:0]      tsent;
    logic [1:0]      busy;
    logic [1:0]      frame_done;
    logic [1:0]      overflow;
    logic [1:0]      timeout_err;
    logic [1:0]      in_full;
    logic [4:0]      cnt_a;
    logic [2:0]      cnt_b;

    link_frame_tx #(
        .WIDTH(8), .DEPTH(16), .CRC_EN(1'b1), .TIMEOUT(10)
    ) u_dut0 (
        .clk(clk), .reset(reset),
        .in_data(in_data[0]), .in_we(in_we[0]), .flush(flush[0]),
        .in_count(cnt_a), .in_full(in_full[0]),
        .t_data(t_data[0]), .tsent(tsent[0]), .trecieve(trecieve[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .crc(crc[0]),
        .overflow(overflow[0]), .timeout_err(timeout_err[0])
    );

    link_frame_tx #(
        .WIDTH(8), .DEPTH(4), .CRC_EN(1'b0), .TIMEOUT(10)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .in_data(in_data[1]), .in_we(in_we[1]), .flush(flush[1]),
        .in_count(cnt_b), .in_full(in_full[1]),
        .t_data(t_data[1]), .tsent(tsent[1]), .trecieve(trecieve[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .crc(crc[1]),
        .overflow(overflow[1]), .timeout_err(timeout_err[1])
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] mf0[$];
    logic [7:0] mf1[$];
    logic [7:0] ex0[$];
    logic [7:0] ex1[$];
    logic [7:0] exp_crc[2];
    int         exp_frames[2];
    int         done_cnt[2];
    int         extra[2];
    int         wait_c[2];
    logic [1:0] tsent_prev;
    logic [1:0] ack_en;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc_ref(logic [7:0] c, logic [7:0] w);
        logic [7:0] r;
        r = c ^ w;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    // Whole model FIFO becomes the expected frame.
    function automatic void model_frame(int d);
        logic [7:0] c;
        logic [7:0] w;
        c = 8'h00;
        if (d == 0) begin
            while (mf0.size() > 0) begin
                w = mf0.pop_front();
                c = crc_ref(c, w);
                ex0.push_back(w);
            end
            ex0.push_back(c);
        end else begin
            while (mf1.size() > 0) begin
                w = mf1.pop_front();
                c = crc_ref(c, w);
                ex1.push_back(w);
            end
        end
        exp_crc[d] = c;
        exp_frames[d]++;
    endfunction

    task automatic enq(int d, logic [7:0] w);
        in_data[d] = w;
        in_we[d]   = 1'b1;
        if (d == 0) begin
            if (mf0.size() < 16) mf0.push_back(w);
        end else begin
            if (mf1.size() < 4) mf1.push_back(w);
        end
        @(negedge clk);
        in_we[d] = 1'b0;
    endtask

    task automatic fl(int d, bit accept);
        flush[d] = 1'b1;
        if (accept) model_frame(d);
        @(negedge clk);
        flush[d] = 1'b0;
    endtask

    task automatic wait_idle(int d);
        int n;
        n = 0;
        while (busy[d] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("frame_end", {31'b0, busy[d]}, 0);
    endtask

    // Link monitor and responder: ack 3 cycles after each tsent edge.
    initial begin
        trecieve   = 2'b00;
        tsent_prev = 2'b00;
        done_cnt   = '{0, 0};
        extra      = '{0, 0};
        wait_c     = '{0, 0};
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (tsent[d] && !tsent_prev[d]) begin
                    if (d == 0 && ex0.size() > 0)
                        check("link_word0", {24'b0, t_data[0]}, {24'b0, ex0.pop_front()});
                    else if (d == 1 && ex1.size() > 0)
                        check("link_word1", {24'b0, t_data[1]}, {24'b0, ex1.pop_front()});
                    else
                        extra[d]++;
                end
                tsent_prev[d] = tsent[d];
                if (frame_done[d]) done_cnt[d]++;
                if (!ack_en[d]) begin
                    trecieve[d] = 1'b0;
                    wait_c[d]   = 0;
                end else if (tsent[d] != trecieve[d]) begin
                    wait_c[d]++;
                    if (wait_c[d] >= 3) begin
                        trecieve[d] = tsent[d];
                        wait_c[d]   = 0;
                    end
                end else begin
                    wait_c[d] = 0;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset      = 1'b1;
        in_data    = '0;
        in_we      = 2'b00;
        flush      = 2'b00;
        ack_en     = 2'b11;
        exp_crc    = '{8'h00, 8'h00};
        exp_frames = '{0, 0};
        repeat (3) @(negedge clk);
        check("rst_tsent", {30'b0, tsent}, 0);
        check("rst_busy", {30'b0, busy}, 0);
        check("rst_flags", {26'b0, overflow, timeout_err, frame_done}, 0);
        check("rst_data", {16'b0, t_data}, 0);
        check("rst_crc", {16'b0, crc}, 0);
        check("rst_count", {24'b0, cnt_b, cnt_a}, 0);
        reset = 1'b0;
        @(negedge clk);

        // single frame with CRC trailer
        enq(0, 8'h01); enq(0, 8'h02); enq(0, 8'h03);
        check("t1_count", {27'b0, cnt_a}, 3);
        fl(0, 1'b1);
        check("t1_busy", {31'b0, busy[0]}, 1);
        @(negedge clk);
        check("t1_data_lead", {23'b0, tsent[0], t_data[0]}, 32'h001);
        @(negedge clk);
        check("t1_tsent", {31'b0, tsent[0]}, 1);
        wait_idle(0);
        check("t1_frames", done_cnt[0], exp_frames[0]);
        check("t1_crc", {24'b0, crc[0]}, 32'h48);
        check("t1_crc_model", {24'b0, crc[0]}, {24'b0, exp_crc[0]});
        check("t1_count_end", {27'b0, cnt_a}, 0);
        check("t1_pending", ex0.size(), 0);

        // depth 4, no CRC: fill, overflow, frame of exactly 4 words
        enq(1, 8'hA0); enq(1, 8'hA1); enq(1, 8'hA2); enq(1, 8'hA3);
        check("t2_full", {31'b0, in_full[1]}, 1);
        check("t2_ovf_pre", {31'b0, overflow[1]}, 0);
        enq(1, 8'hA4);
        check("t2_ovf", {31'b0, overflow[1]}, 1);
        check("t2_count", {29'b0, cnt_b}, 4);
        fl(1, 1'b1);
        wait_idle(1);
        check("t2_frames", done_cnt[1], exp_frames[1]);
        check("t2_pending", ex1.size(), 0);
        check("t2_crc", {24'b0, crc[1]}, {24'b0, exp_crc[1]});
        check("t2_notfull", {31'b0, in_full[1]}, 0);

        // write during a frame stays for the next one
        enq(0, 8'h10); enq(0, 8'h20);
        fl(0, 1'b1);
        repeat (4) @(negedge clk);
        enq(0, 8'h55);
        wait_idle(0);
        check("t3_count", {27'b0, cnt_a}, 1);
        check("t3_frames", done_cnt[0], exp_frames[0]);
        check("t3_crc", {24'b0, crc[0]}, {24'b0, exp_crc[0]});
        fl(0, 1'b1);
        wait_idle(0);
        check("t3_crc2", {24'b0, crc[0]}, {24'b0, exp_crc[0]});
        check("t3_count2", {27'b0, cnt_a}, 0);

        // flush while busy and flush while empty are ignored
        enq(0, 8'h66); enq(0, 8'h77);
        fl(0, 1'b1);
        fl(0, 1'b0);
        wait_idle(0);
        check("t6_frames", done_cnt[0], exp_frames[0]);
        check("t6_pending", ex0.size(), 0);
        fl(0, 1'b0);
        check("t6_empty_busy", {31'b0, busy[0]}, 0);
        repeat (8) @(negedge clk);
        check("t6_empty_frames", done_cnt[0], exp_frames[0]);
        check("t6_no_word", extra[0], 0);

        // handshake timeout with no acknowledge
        ack_en[0] = 1'b0;
        enq(0, 8'hC1); enq(0, 8'hC2); enq(0, 8'hC3);
        flush[0] = 1'b1;
        ex0.push_back(mf0.pop_front());
        @(negedge clk);
        flush[0] = 1'b0;
        n = 0;
        while (!tsent[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_tsent", {31'b0, tsent[0]}, 1);
        repeat (9) @(negedge clk);
        check("t4_before", {30'b0, timeout_err[0], tsent[0]}, 32'h1);
        @(negedge clk);
        check("t4_tmo", {29'b0, timeout_err[0], tsent[0], busy[0]}, 32'h4);
        check("t4_count", {27'b0, cnt_a}, 2);
        check("t4_frames", done_cnt[0], exp_frames[0]);
        check("t4_crc", {24'b0, crc[0]}, {24'b0, exp_crc[0]});
        ack_en[0] = 1'b1;
        repeat (2) @(negedge clk);
        fl(0, 1'b1);
        check("t4_clear", {31'b0, timeout_err[0]}, 0);
        wait_idle(0);
        check("t4_crc2", {24'b0, crc[0]}, {24'b0, exp_crc[0]});
        check("t4_frames2", done_cnt[0], exp_frames[0]);

        // reset during WAIT_LO
        enq(0, 8'hD1); enq(0, 8'hD2); enq(0, 8'hD3);
        flush[0] = 1'b1;
        ex0.push_back(mf0.pop_front());
        @(negedge clk);
        flush[0] = 1'b0;
        n = 0;
        while (!(busy[0] && !tsent[0] && trecieve[0]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_wait_lo", {30'b0, busy[0], trecieve[0]}, 32'h3);
        reset = 1'b1;
        #1;
        check("t5_async", {26'b0, tsent[0], busy[0], cnt_a}, 0);
        mf0.delete();
        exp_crc = '{8'h00, 8'h00};
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_crc", {24'b0, crc[0]}, {24'b0, exp_crc[0]});
        check("t5_ovf", {31'b0, overflow[1]}, 0);
        fl(0, 1'b0);
        repeat (8) @(negedge clk);
        check("t5_ignored", {31'b0, busy[0]}, 0);
        check("t5_frames", done_cnt[0], exp_frames[0]);
        check("t5_pending", ex0.size(), 0);

        check("extra_words0", extra[0], 0);
        check("extra_words1", extra[1], 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/link_frame_tx.md
# link_frame_tx

Parametrised frame transmitter between the UART receive path and the parallel inter-board link. It buffers words in an internal FIFO of configurable depth and width. On a flush request it sends the buffered words as one frame over the `t_data`/`tsent`/`trecieve` four-phase handshake, optionally followed by a CRC-8 trailer word. It adds a handshake timeout and an overflow flag, which the fixed 8-bit FIFO-to-link path lacks.

## Interface
Parameters:
- `WIDTH`, 8, link and FIFO word width; must be ≥ 8.
- `DEPTH`, 16, FIFO depth; must be a power of two, ≥ 2.
- `CRC_EN`, 1, append CRC trailer word when 1.
- `TIMEOUT`, 4095, maximum cycles spent waiting on `trecieve` in one handshake phase.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  word to enqueue.
- `in_we`  in  1  enqueue strobe, one word per cycle.
- `flush`  in  1  single-cycle request to send the current FIFO contents as a frame.
- `in_count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `in_full`  out  1  `in_count == DEPTH`.
- `t_data`  out  WIDTH  link data.
- `tsent`  out  1  link data-valid.
- `trecieve`  in  1  link acknowledge; already synchronised upstream.
- `busy`  out  1  a frame is in progress.
- `frame_done`  out  1  one-cycle pulse when a frame completes normally.
- `crc`  out  8  CRC of the last completed frame.
- `overflow`  out  1  sticky; set by `in_we` while full.
- `timeout_err`  out  1  sticky; set when a frame is aborted by timeout.

## Operation
- **Reset values:** every output is 0 and the FIFO is empty.
- **FIFO:** circular buffer, with read and write pointers of width $clog2(DEPTH)+1.
  - Simultaneous enqueue and dequeue are allowed, including when the FIFO is full.
  - `in_we` while full and not dequeuing that cycle drops the word and sets `overflow`.
- **Frame length:** `LEN` = `in_count` sampled at `flush`. Words written during a frame remain for the next frame.
- **Ignored flush:** `flush` is ignored while `busy`, and ignored when `in_count == 0` (no frame, no pulse).
- **FSM states:** IDLE, SETUP, ASSERT, WAIT_HI, DEASSERT, WAIT_LO, CRC_SETUP, DONE.
  - IDLE → SETUP on an accepted flush. Clear `timeout_err`, clear the running CRC, and latch `LEN`.
  - SETUP: dequeue one word onto `t_data`, fold it into the running CRC, decrement the remaining count. → ASSERT.
  - ASSERT: `tsent`=1. → WAIT_HI.
  - WAIT_HI: hold until `trecieve`=1. → DEASSERT.
  - DEASSERT: `tsent`=0. → WAIT_LO.
  - WAIT_LO: hold until `trecieve`=0. Then:
    - → SETUP if words remain;
    - else → CRC_SETUP if `CRC_EN` and the trailer has not been sent;
    - else → DONE.
  - CRC_SETUP: `t_data` = {zeros, running CRC}. → ASSERT. The trailer is not folded into the CRC.
  - DONE: update `crc`, pulse `frame_done`. → IDLE.
- **`busy`:** 1 in every state except IDLE.
- **CRC-8:**
  - Polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Each word is processed MSB-first over all WIDTH bits, one word per cycle as a combinational loop.
- **Timeout:** a counter runs in WAIT_HI and WAIT_LO and resets on each state entry. When it reaches `TIMEOUT`:
  - set `timeout_err`, force `tsent`=0, → IDLE;
  - no `frame_done` pulse, `crc` is unchanged;
  - words not yet dequeued stay in the FIFO.
- **Reset mid-frame:** the FIFO is emptied, `tsent` drops immediately, and the state goes to IDLE.

## Timing
- `in_we` at cycle n: `in_count` reflects the new word at n+1.
- `flush` sampled at edge n:
  - SETUP at n+1;
  - `t_data` valid at n+2;
  - `tsent` high at n+3, so data leads `tsent` by one cycle.
- `trecieve` rising seen at edge m: `tsent` falls at m+2.
- `trecieve` falling seen at edge k: the next word's `t_data` appears at k+2.
- `t_data` holds its value from SETUP until the next SETUP or CRC_SETUP.
- `frame_done` is asserted one cycle after the last WAIT_LO exit; `crc` is valid from that same cycle.

## Structure
- Shared package `link_pkg`:
  - FSM state enum;
  - `CRC8_POLY` = 8'h07;
  - function `crc8_word(crc, word)`.
- One natural sub-module: `sync_fifo` (WIDTH, DEPTH), providing count, full, empty and same-cycle read/write.
- The FSM, timeout counter and CRC register live in the top level.

## Test plan
- **Single frame with CRC:** enqueue 0x01, 0x02, 0x03, flush; responder acks each word after 3 cycles → link carries 0x01, 0x02, 0x03, 0x48; `crc`=0x48; one `frame_done`; `in_count`=0.
- **`CRC_EN`=0, DEPTH=4:** fill with 0xA0–0xA3 → `in_full`=1. A 5th write → `overflow`=1, word dropped; the frame carries exactly 4 words.
- **Writes during frame:** flush with 2 words, then enqueue 0x55 mid-frame → frame sends 2 words (+CRC); `in_count`=1 after `frame_done`.
- **Timeout:** `TIMEOUT`=10, responder never acks → `timeout_err`=1 at cycle 10 of WAIT_HI; `tsent`=0; `busy`=0; remaining words still counted in `in_count`.
- **Reset mid-frame:** assert `reset` in WAIT_LO → `tsent`, `busy`, `in_count` = 0 asynchronously; the next flush is ignored because the FIFO is empty.
- **Ignored flush:** flush while `busy` → no second frame. Flush with `in_count`=0 → no handshake and no `frame_done`.
